// File: rtl/rng_pkg.sv
// Shared constants, default tap masks and FSM state type for the wide LFSR generator.
package rng_pkg;

   localparam int unsigned MODE_GALOIS    = 0;
   localparam int unsigned MODE_FIBONACCI = 1;

   // Right-shift Galois tap masks of maximal-length polynomials.
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;
   localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

   localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_D4A5_6AAD;

   typedef enum logic {StFill, StHold} rng_state_e;

   function automatic logic [63:0] default_taps(int unsigned width);
      case (width)
         8:       return 64'(TAPS_8);
         16:      return 64'(TAPS_16);
         64:      return TAPS_64;
         default: return 64'(TAPS_32);
      endcase
   endfunction

endpackage

// File: rtl/lfsr_wide_rng_if.sv
// Valid/ready delivery channel for wide random words.
interface lfsr_wide_rng_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned WORDS = 4
);
   logic [WIDTH*WORDS-1:0] rng_out;
   logic                   rng_valid;
   logic                   rng_ready;

   modport master (output rng_out, output rng_valid, input rng_ready);
   modport slave  (input rng_out, input rng_valid, output rng_ready);
endinterface

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state function, Galois (right shift) or Fibonacci (left shift).
module lfsr_step import rng_pkg::*; #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32),
   parameter int unsigned      MODE  = MODE_GALOIS
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   if (MODE == MODE_FIBONACCI) begin : g_fib
      assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
   end else begin : g_galois
      assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
   end

endmodule

// File: rtl/lfsr_wide_rng.sv
// Wide random-word generator: concatenates WORDS successive LFSR states per output word
// and hands each word to the consumer over a valid/ready channel.
module lfsr_wide_rng import rng_pkg::*; #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int unsigned      MODE  = MODE_GALOIS,
   parameter int unsigned      WORDS = 4,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   lfsr_wide_rng_if.master  rng
);

   localparam int unsigned     AccW    = WIDTH * WORDS;
   localparam int unsigned     CntW    = $clog2(WORDS + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WORDS);

   if (SEED == '0) begin : g_chk_seed
      $error("lfsr_wide_rng: SEED must be non-zero");
   end
   if (MODE == MODE_GALOIS && !TAPS[WIDTH-1]) begin : g_chk_taps
      $error("lfsr_wide_rng: Galois TAPS must have its top bit set");
   end
   if (WORDS < 1 || WORDS > 64) begin : g_chk_words
      $error("lfsr_wide_rng: WORDS out of range");
   end
   if (WIDTH < 8 || WIDTH > 64) begin : g_chk_width
      $error("lfsr_wide_rng: WIDTH out of range");
   end

   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_n;
   logic [AccW-1:0]  acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   rng_state_e       state_q, state_d;
   logic             step;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_step (
      .cur (lfsr_q),
      .nxt (lfsr_n)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= StFill;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
      end
   end

   // A handshake edge with en high is also the first step of the next fill.
   assign step = en && (state_q == StFill || rng.rng_ready);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (seed_load) begin
         lfsr_d  = (seed_in == '0) ? SEED : seed_in;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = StFill;
      end else begin
         if (state_q == StHold && rng.rng_ready) state_d = StFill;
         if (step) begin
            lfsr_d = lfsr_n;
            acc_d  = AccW'({acc_q, lfsr_n});
            if (cnt_q == CntLast - 1'b1) begin
               cnt_d   = '0;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rng.rng_valid = (state_q == StHold);
      rng.rng_out   = acc_q;
   end

endmodule

// File: tb/tb_lfsr_wide_rng.sv
// Directed bench for lfsr_wide_rng: 32-bit Galois fill/handshake/seeding plus 8-bit period runs.
module tb_lfsr_wide_rng;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en32, seed_load32, en8, seed_load8;
   logic [31:0] seed_in32;
   logic [7:0]  seed_in8;
   int          checks = 0;
   int          failures = 0;

   logic        en_pat [6];
   logic [63:0] exp_out [6];
   logic        exp_v [6];
   int          period_g, period_f;
   logic        zero_seen, valid_drop;

   lfsr_wide_rng_if #(.WIDTH(32), .WORDS(2)) bus32 ();
   lfsr_wide_rng_if #(.WIDTH(8),  .WORDS(1)) bus_g8 ();
   lfsr_wide_rng_if #(.WIDTH(8),  .WORDS(1)) bus_f8 ();

   lfsr_wide_rng #(
      .WIDTH (32), .TAPS (32'h8020_0003), .MODE (0), .WORDS (2), .SEED (32'hD4A5_6AAD)
   ) u_dut32 (
      .clk (clk), .rst (rst), .en (en32), .seed_load (seed_load32), .seed_in (seed_in32),
      .rng (bus32)
   );

   lfsr_wide_rng #(
      .WIDTH (8), .TAPS (8'hB8), .MODE (0), .WORDS (1), .SEED (8'h01)
   ) u_dut_g8 (
      .clk (clk), .rst (rst), .en (en8), .seed_load (seed_load8), .seed_in (seed_in8),
      .rng (bus_g8)
   );

   lfsr_wide_rng #(
      .WIDTH (8), .TAPS (8'hB8), .MODE (1), .WORDS (1), .SEED (8'h01)
   ) u_dut_f8 (
      .clk (clk), .rst (rst), .en (en8), .seed_load (seed_load8), .seed_in (seed_in8),
      .rng (bus_f8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en32 = 1'b0; seed_load32 = 1'b0; seed_in32 = '0;
      en8 = 1'b0; seed_load8 = 1'b0; seed_in8 = '0;
      bus32.rng_ready = 1'b0; bus_g8.rng_ready = 1'b0; bus_f8.rng_ready = 1'b0;
      tick(); tick();
      check1("reset_valid", bus32.rng_valid, 1'b0);
      check64("reset_out", bus32.rng_out, 64'h0);
      check1("reset_valid_g8", bus_g8.rng_valid, 1'b0);

      // First word after reset release
      rst = 1'b0; en32 = 1'b1;
      tick();
      check1("fill1_valid", bus32.rng_valid, 1'b0);
      check64("fill1_out", bus32.rng_out, 64'h0000_0000_EA72_B555);
      tick();
      check1("word1_valid", bus32.rng_valid, 1'b1);
      check64("word1_out", bus32.rng_out, 64'hEA72_B555_F519_5AA9);
      for (int i = 0; i < 10; i++) begin
         tick();
         check1("hold_valid", bus32.rng_valid, 1'b1);
         check64("hold_out", bus32.rng_out, 64'hEA72_B555_F519_5AA9);
      end

      // Single handshake edge, then continuous streaming
      bus32.rng_ready = 1'b1;
      tick();
      bus32.rng_ready = 1'b0;
      check1("hs_valid", bus32.rng_valid, 1'b0);
      check64("hs_out", bus32.rng_out, 64'hF519_5AA9_FAAC_AD57);
      tick();
      check1("word2_valid", bus32.rng_valid, 1'b1);
      check64("word2_out", bus32.rng_out, 64'hFAAC_AD57_FD76_56A8);
      bus32.rng_ready = 1'b1;
      tick();
      check1("stream_a_valid", bus32.rng_valid, 1'b0);
      check64("stream_a_out", bus32.rng_out, 64'hFD76_56A8_7EBB_2B54);
      tick();
      check1("stream_b_valid", bus32.rng_valid, 1'b1);
      check64("stream_b_out", bus32.rng_out, 64'h7EBB_2B54_3F5D_95AA);
      tick();
      check1("stream_c_valid", bus32.rng_valid, 1'b0);
      tick();
      check1("stream_d_valid", bus32.rng_valid, 1'b1);
      check64("stream_d_out", bus32.rng_out, 64'h1FAE_CAD5_8FF7_6569);
      tick();
      check1("midfill_valid", bus32.rng_valid, 1'b0);
      check64("midfill_out", bus32.rng_out, 64'h8FF7_6569_C7DB_B2B7);

      // Zero seed mid-fill falls back to SEED; sequence restarts as after reset
      bus32.rng_ready = 1'b0; seed_load32 = 1'b1; seed_in32 = '0;
      tick();
      seed_load32 = 1'b0;
      check1("seed0_valid", bus32.rng_valid, 1'b0);
      check64("seed0_out", bus32.rng_out, 64'h0);
      tick();
      check64("seed0_fill1", bus32.rng_out, 64'h0000_0000_EA72_B555);
      tick();
      check1("seed0_word_valid", bus32.rng_valid, 1'b1);
      check64("seed0_word", bus32.rng_out, 64'hEA72_B555_F519_5AA9);

      // seed_load beats a coincident handshake with en high: no step that edge
      seed_load32 = 1'b1; seed_in32 = 32'h0000_0001; bus32.rng_ready = 1'b1;
      tick();
      seed_load32 = 1'b0; bus32.rng_ready = 1'b0;
      check1("seedhs_valid", bus32.rng_valid, 1'b0);
      check64("seedhs_out", bus32.rng_out, 64'h0);
      tick();
      check1("seedhs_fill1_valid", bus32.rng_valid, 1'b0);
      check64("seedhs_fill1", bus32.rng_out, 64'h0000_0000_8020_0003);
      tick();
      check1("seedhs_word_valid", bus32.rng_valid, 1'b1);
      check64("seedhs_word", bus32.rng_out, 64'h8020_0003_C030_0002);

      // en toggling during a fill keeps the partial word
      seed_load32 = 1'b1;
      tick();
      seed_load32 = 1'b0;
      en_pat  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_v   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_out = '{64'h0, 64'h0000_0000_8020_0003, 64'h0000_0000_8020_0003,
                  64'h0000_0000_8020_0003, 64'h8020_0003_C030_0002, 64'h8020_0003_C030_0002};
      for (int i = 0; i < 6; i++) begin
         en32 = en_pat[i];
         tick();
         check1("entog_valid", bus32.rng_valid, exp_v[i]);
         check64("entog_out", bus32.rng_out, exp_out[i]);
      end
      en32 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check64("hold_en_out", bus32.rng_out, 64'h8020_0003_C030_0002);
      end

      // rst mid-fill discards the partial word
      bus32.rng_ready = 1'b1;
      tick();
      bus32.rng_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check1("rst_fill_valid", bus32.rng_valid, 1'b0);
      check64("rst_fill_out", bus32.rng_out, 64'h0);
      tick(); tick();
      check64("rst_word", bus32.rng_out, 64'hEA72_B555_F519_5AA9);

      // 8-bit period runs, WORDS=1: a new word on every cycle
      en8 = 1'b1; bus_g8.rng_ready = 1'b1; bus_f8.rng_ready = 1'b1;
      tick();
      check1("g8_first_valid", bus_g8.rng_valid, 1'b1);
      check64("g8_first", 64'(bus_g8.rng_out), 64'h0000_0000_0000_00B8);
      check64("f8_first", 64'(bus_f8.rng_out), 64'h0000_0000_0000_0002);
      period_g = 0; period_f = 0; zero_seen = 1'b0; valid_drop = 1'b0;
      for (int k = 2; k <= 300; k++) begin
         tick();
         if (bus_g8.rng_out == 8'h00 || bus_f8.rng_out == 8'h00) zero_seen = 1'b1;
         if (!bus_g8.rng_valid || !bus_f8.rng_valid) valid_drop = 1'b1;
         if (period_g == 0 && bus_g8.rng_out == 8'h01) period_g = k;
         if (period_f == 0 && bus_f8.rng_out == 8'h01) period_f = k;
         if (period_g != 0 && period_f != 0) break;
      end
      check64("g8_period", 64'(period_g), 64'd255);
      check64("f8_period", 64'(period_f), 64'd255);
      check1("p8_zero_seen", zero_seen, 1'b0);
      check1("p8_valid_drop", valid_drop, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
